// File: rtl/rpc_config_path_pkg.sv
// Shared types for the RPC configuration path: command source tags, the
// command arbiter state encoding and the arbiter grant vector.
//   cmd_src_e   : which requester produced the command on the CMD_FSM port
//   arb_state_e : output-stage occupancy of rpc_cmd_arbiter
//   grant_t     : one-hot grant from rpc_cmd_prio_sel (all-zero = no winner)
package rpc_config_path_pkg;

   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_REF    = 2'd1,
      SRC_ZQC    = 2'd2,
      SRC_DIRECT = 2'd3
   } cmd_src_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic ref_g;
      logic zqc_g;
      logic dir_g;
   } grant_t;

   localparam int unsigned RPC_CMD_WIDTH = 19;

   function automatic cmd_src_e grant_to_src(input grant_t g);
      cmd_src_e src;
      src = SRC_NONE;
      if (g.ref_g) begin
         src = SRC_REF;
      end else if (g.zqc_g) begin
         src = SRC_ZQC;
      end else if (g.dir_g) begin
         src = SRC_DIRECT;
      end
      return src;
   endfunction

   function automatic logic grant_any(input grant_t g);
      return g.ref_g | g.zqc_g | g.dir_g;
   endfunction

endpackage

// File: rtl/rpc_cmd_prio_sel.sv
// Combinational priority select for the RPC command arbiter.
// Turns the three eligibility flags plus the direct-command aging boost into
// a one-hot grant. Normal order is ref > zqc > direct; while boost_i is high
// an eligible direct command jumps to the top.
// Ports:
//   ref_elig_i  : refresh request eligible (already gated by init)
//   zqc_elig_i  : ZQ-cal request eligible (already gated by init)
//   dir_elig_i  : direct command request eligible
//   boost_i     : direct command has aged out and takes top priority
//   grant_o     : one-hot grant, all-zero when nothing is eligible
module rpc_cmd_prio_sel
   import rpc_config_path_pkg::*;
(
   input  logic   ref_elig_i,
   input  logic   zqc_elig_i,
   input  logic   dir_elig_i,
   input  logic   boost_i,
   output grant_t grant_o
);

   always_comb begin
      grant_o = '0;
      if (boost_i && dir_elig_i) begin
         grant_o.dir_g = 1'b1;
      end else if (ref_elig_i) begin
         grant_o.ref_g = 1'b1;
      end else if (zqc_elig_i) begin
         grant_o.zqc_g = 1'b1;
      end else if (dir_elig_i) begin
         grant_o.dir_g = 1'b1;
      end
   end

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// Shares the single RPC DRAM command port between the refresh timer, the
// ZQ-calibration timer and the direct-command FIFO. Fixed priority with an
// aging boost for direct commands, one registered output stage towards
// CMD_FSM. Timer commands are held off until DRAM init has completed.
// Ports:
//   clk_i, rst_ni                  : clock, async active-low reset
//   rpc_init_completed_i           : enables refresh / ZQ-cal requests
//   ref_*  / zqc_* / direct_cmd_*  : valid/ready/cmd per requester
//   cmd_valid_o/cmd_ready_i/cmd_o  : command towards CMD_FSM
//   cmd_src_o                      : requester that produced cmd_o
//   direct_boost_o                 : aging boost active (status)
//
// state    | meaning
// ARB_IDLE | output stage empty, any eligible request is accepted
// ARB_BUSY | output stage holds a command until CMD_FSM takes it
module rpc_cmd_arbiter
   import rpc_config_path_pkg::*;
#(
   parameter int unsigned CMD_WIDTH       = 19,
   parameter int unsigned MAX_DIRECT_WAIT = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rpc_init_completed_i,
   input  logic                 ref_valid_i,
   output logic                 ref_ready_o,
   input  logic [CMD_WIDTH-1:0] ref_cmd_i,
   input  logic                 zqc_valid_i,
   output logic                 zqc_ready_o,
   input  logic [CMD_WIDTH-1:0] zqc_cmd_i,
   input  logic                 direct_cmd_valid_i,
   output logic                 direct_cmd_ready_o,
   input  logic [CMD_WIDTH-1:0] direct_cmd_i,
   output logic                 cmd_valid_o,
   input  logic                 cmd_ready_i,
   output logic [CMD_WIDTH-1:0] cmd_o,
   output cmd_src_e             cmd_src_o,
   output logic                 direct_boost_o
);

   localparam int unsigned      CNT_W   = $clog2(MAX_DIRECT_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIRECT_WAIT);

   arb_state_e           state_q, state_d;
   logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
   cmd_src_e             src_q, src_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 slot_free;
   logic                 boost;
   logic                 ref_elig;
   logic                 zqc_elig;
   logic                 dir_elig;
   grant_t               grant;
   grant_t               grant_en;
   logic                 win_any;
   logic [CMD_WIDTH-1:0] win_cmd;
   cmd_src_e             win_src;

   // Direct commands are legal during init, timer commands are not.
   assign ref_elig = ref_valid_i & rpc_init_completed_i;
   assign zqc_elig = zqc_valid_i & rpc_init_completed_i;
   assign dir_elig = direct_cmd_valid_i;

   // The output stage can take a new command when empty or when it is
   // being emptied this very cycle (back-to-back, no bubble).
   assign slot_free = (state_q == ARB_IDLE) || cmd_ready_i;
   assign boost     = (cnt_q == CNT_MAX);

   rpc_cmd_prio_sel u_prio_sel (
      .ref_elig_i (ref_elig),
      .zqc_elig_i (zqc_elig),
      .dir_elig_i (dir_elig),
      .boost_i    (boost),
      .grant_o    (grant)
   );

   assign grant_en = slot_free ? grant : '0;
   assign win_any  = grant_any(grant_en);
   assign win_src  = grant_to_src(grant_en);

   always_comb begin
      win_cmd = '0;
      if (grant_en.ref_g) begin
         win_cmd = ref_cmd_i;
      end else if (grant_en.zqc_g) begin
         win_cmd = zqc_cmd_i;
      end else if (grant_en.dir_g) begin
         win_cmd = direct_cmd_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      src_d   = src_q;
      case (state_q)
         ARB_IDLE: begin
            if (win_any) begin
               state_d = ARB_BUSY;
               cmd_d   = win_cmd;
               src_d   = win_src;
            end
         end
         ARB_BUSY: begin
            if (cmd_ready_i) begin
               if (win_any) begin
                  cmd_d = win_cmd;
                  src_d = win_src;
               end else begin
                  state_d = ARB_IDLE;
                  cmd_d   = '0;
                  src_d   = SRC_NONE;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            cmd_d   = '0;
            src_d   = SRC_NONE;
         end
      endcase
   end

   // A pending direct command that is not granted in a free slot has always
   // lost to someone, because it would otherwise have won by default.
   always_comb begin
      cnt_d = cnt_q;
      if (!direct_cmd_valid_i || grant_en.dir_g) begin
         cnt_d = '0;
      end else if (slot_free && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         cmd_q   <= '0;
         src_q   <= SRC_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ref_ready_o        = grant_en.ref_g;
   assign zqc_ready_o        = grant_en.zqc_g;
   assign direct_cmd_ready_o = grant_en.dir_g;
   assign cmd_valid_o        = (state_q == ARB_BUSY);
   assign cmd_o              = cmd_q;
   assign cmd_src_o          = src_q;
   assign direct_boost_o     = boost;

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
module tb_rpc_cmd_arbiter;
   import rpc_config_path_pkg::*;

   localparam int CW = 19;
   localparam int MW = 4;
   localparam int N_NONE = 0;
   localparam int N_REF  = 1;
   localparam int N_ZQC  = 2;
   localparam int N_DIR  = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          rpc_init_completed_i;
   logic          ref_valid_i;
   logic          ref_ready_o;
   logic [CW-1:0] ref_cmd_i;
   logic          zqc_valid_i;
   logic          zqc_ready_o;
   logic [CW-1:0] zqc_cmd_i;
   logic          direct_cmd_valid_i;
   logic          direct_cmd_ready_o;
   logic [CW-1:0] direct_cmd_i;
   logic          cmd_valid_o;
   logic          cmd_ready_i;
   logic [CW-1:0] cmd_o;
   cmd_src_e      cmd_src_o;
   logic          direct_boost_o;

   rpc_cmd_arbiter #(.CMD_WIDTH(CW), .MAX_DIRECT_WAIT(MW)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .rpc_init_completed_i (rpc_init_completed_i),
      .ref_valid_i          (ref_valid_i),
      .ref_ready_o          (ref_ready_o),
      .ref_cmd_i            (ref_cmd_i),
      .zqc_valid_i          (zqc_valid_i),
      .zqc_ready_o          (zqc_ready_o),
      .zqc_cmd_i            (zqc_cmd_i),
      .direct_cmd_valid_i   (direct_cmd_valid_i),
      .direct_cmd_ready_o   (direct_cmd_ready_o),
      .direct_cmd_i         (direct_cmd_i),
      .cmd_valid_o          (cmd_valid_o),
      .cmd_ready_i          (cmd_ready_i),
      .cmd_o                (cmd_o),
      .cmd_src_o            (cmd_src_o),
      .direct_boost_o       (direct_boost_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: what the output stage holds, and how many free slots
   // the current direct request has lost so far.
   bit            m_busy;
   logic [CW-1:0] m_cmd;
   int            m_src;
   int            m_losses;
   int            last_win;
   int            dir_lost;
   logic [CW+1:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input bit fr, input bit boost);
      bit r, z, d;
      r = ref_valid_i && rpc_init_completed_i;
      z = zqc_valid_i && rpc_init_completed_i;
      d = direct_cmd_valid_i;
      if (!fr) return N_NONE;
      if (boost && d) return N_DIR;
      if (r) return N_REF;
      if (z) return N_ZQC;
      if (d) return N_DIR;
      return N_NONE;
   endfunction

   task automatic model_reset();
      m_busy   = 1'b0;
      m_cmd    = '0;
      m_src    = N_NONE;
      m_losses = 0;
      last_win = N_NONE;
      dir_lost = 0;
      sb_q.delete();
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      int            win;
      bit            fr;
      bit            boost;
      logic [CW-1:0] wcmd;
      logic [CW+1:0] exp_e;
      #1;
      fr    = !m_busy || cmd_ready_i;
      boost = (m_losses >= MW);
      win   = pick(fr, boost);
      chk("cmd_valid", 32'(cmd_valid_o), 32'(m_busy));
      chk("cmd_src", 32'(cmd_src_o), 32'(m_src));
      chk("cmd", 32'(cmd_o), 32'(m_cmd));
      chk("boost", 32'(direct_boost_o), 32'(boost));
      chk("ref_ready", 32'(ref_ready_o), 32'(win == N_REF));
      chk("zqc_ready", 32'(zqc_ready_o), 32'(win == N_ZQC));
      chk("dir_ready", 32'(direct_cmd_ready_o), 32'(win == N_DIR));
      // scoreboard driven by the DUT's own handshakes
      if (cmd_valid_o && cmd_ready_i) begin
         chk("sb_depth", 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            exp_e = sb_q.pop_front();
            chk("sb_order", 32'({cmd_src_o, cmd_o}), 32'(exp_e));
         end
      end
      if (ref_ready_o) sb_q.push_back({SRC_REF, ref_cmd_i});
      if (zqc_ready_o) sb_q.push_back({SRC_ZQC, zqc_cmd_i});
      if (direct_cmd_ready_o) sb_q.push_back({SRC_DIRECT, direct_cmd_i});
      if (!direct_cmd_valid_i) begin
         dir_lost = 0;
      end else if (direct_cmd_ready_o) begin
         chk("dir_wait", 32'(dir_lost <= MW), 32'd1);
         dir_lost = 0;
      end else if (ref_ready_o || zqc_ready_o) begin
         dir_lost++;
      end
      wcmd = (win == N_REF) ? ref_cmd_i : (win == N_ZQC) ? zqc_cmd_i : direct_cmd_i;
      @(posedge clk_i);
      if (fr) begin
         if (win != N_NONE) begin
            m_busy = 1'b1;
            m_cmd  = wcmd;
            m_src  = win;
         end else begin
            m_busy = 1'b0;
            m_cmd  = '0;
            m_src  = N_NONE;
         end
      end
      if (!direct_cmd_valid_i || win == N_DIR) m_losses = 0;
      else if (fr && m_losses < MW) m_losses++;
      last_win = win;
      @(negedge clk_i);
   endtask

   task automatic drop_winner();
      if (last_win == N_REF) ref_valid_i = 1'b0;
      if (last_win == N_ZQC) zqc_valid_i = 1'b0;
      if (last_win == N_DIR) direct_cmd_valid_i = 1'b0;
   endtask

   // ref/zqc re-request with a fresh cmd whenever they win
   task automatic age_run(input int n);
      for (int i = 0; i < n; i++) begin
         cycle();
         if (last_win == N_REF) ref_cmd_i = CW'(32'h1000 + i);
         if (last_win == N_ZQC) zqc_cmd_i = CW'(32'h2000 + i);
      end
   endtask

   initial begin
      rst_ni               = 1'b0;
      rpc_init_completed_i = 1'b0;
      ref_valid_i          = 1'b0;
      zqc_valid_i          = 1'b0;
      direct_cmd_valid_i   = 1'b0;
      ref_cmd_i            = '0;
      zqc_cmd_i            = '0;
      direct_cmd_i         = '0;
      cmd_ready_i          = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 32'(cmd_valid_o), 32'd0);
      chk("rst_src", 32'(cmd_src_o), 32'(SRC_NONE));
      chk("rst_cmd", 32'(cmd_o), 32'd0);
      chk("rst_boost", 32'(direct_boost_o), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // init gating
      ref_valid_i = 1'b1; ref_cmd_i = 19'h10001;
      direct_cmd_valid_i = 1'b1; direct_cmd_i = 19'h000AA;
      cmd_ready_i = 1'b1;
      cycle();
      chk("t1_cmd", 32'(cmd_o), 32'h000AA);
      chk("t1_src", 32'(cmd_src_o), 32'(SRC_DIRECT));
      drop_winner();
      cycle();
      rpc_init_completed_i = 1'b1;
      cycle();
      chk("t1_ref_src", 32'(cmd_src_o), 32'(SRC_REF));
      chk("t1_ref_cmd", 32'(cmd_o), 32'h10001);
      drop_winner();

      // priority
      ref_valid_i = 1'b1; ref_cmd_i = 19'h01111;
      zqc_valid_i = 1'b1; zqc_cmd_i = 19'h02222;
      direct_cmd_valid_i = 1'b1; direct_cmd_i = 19'h03333;
      cycle(); drop_winner();
      chk("t2_src0", 32'(cmd_src_o), 32'(SRC_REF));
      cycle(); drop_winner();
      chk("t2_src1", 32'(cmd_src_o), 32'(SRC_ZQC));
      cycle(); drop_winner();
      chk("t2_src2", 32'(cmd_src_o), 32'(SRC_DIRECT));
      chk("t2_valid", 32'(cmd_valid_o), 32'd1);
      cycle();
      chk("t2_idle", 32'(cmd_valid_o), 32'd0);

      // backpressure
      cmd_ready_i = 1'b0;
      ref_valid_i = 1'b1; ref_cmd_i = 19'h04444;
      cycle(); drop_winner();
      zqc_valid_i = 1'b1; zqc_cmd_i = 19'h05555;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("t3_hold_cmd", 32'(cmd_o), 32'h04444);
         chk("t3_hold_src", 32'(cmd_src_o), 32'(SRC_REF));
      end
      cmd_ready_i = 1'b1;
      #1;
      chk("t3_release", 32'(zqc_ready_o), 32'd1);
      cycle(); drop_winner();
      cycle();

      // aging
      direct_cmd_valid_i = 1'b1; direct_cmd_i = 19'h06666;
      ref_valid_i = 1'b1; zqc_valid_i = 1'b1;
      age_run(MW);
      chk("t4_boost", 32'(direct_boost_o), 32'd1);
      chk("t4_dir_ready", 32'(direct_cmd_ready_o), 32'd1);
      cycle();
      chk("t4_boost_clr", 32'(direct_boost_o), 32'd0);
      chk("t4_src", 32'(cmd_src_o), 32'(SRC_DIRECT));

      // async reset mid-BUSY
      direct_cmd_i = 19'h07777;
      age_run(MW);
      chk("t5_boost_pre", 32'(direct_boost_o), 32'd1);
      cmd_ready_i = 1'b0;
      cycle();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t5_valid", 32'(cmd_valid_o), 32'd0);
      chk("t5_src", 32'(cmd_src_o), 32'(SRC_NONE));
      chk("t5_boost", 32'(direct_boost_o), 32'd0);
      chk("t5_cmd", 32'(cmd_o), 32'd0);
      model_reset();
      ref_valid_i = 1'b0; zqc_valid_i = 1'b0; direct_cmd_valid_i = 1'b0;
      rpc_init_completed_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      ref_valid_i = 1'b1; ref_cmd_i = 19'h10001;
      direct_cmd_valid_i = 1'b1; direct_cmd_i = 19'h000AA;
      cmd_ready_i = 1'b1;
      cycle();
      chk("t5_post_src", 32'(cmd_src_o), 32'(SRC_DIRECT));
      chk("t5_post_cmd", 32'(cmd_o), 32'h000AA);
      drop_winner();
      ref_valid_i = 1'b0;
      cycle();

      // constrained random
      rpc_init_completed_i = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) rpc_init_completed_i = ~rpc_init_completed_i;
         if (!ref_valid_i && $urandom_range(0, 2) == 0) begin
            ref_valid_i = 1'b1; ref_cmd_i = CW'($urandom);
         end
         if (!zqc_valid_i && $urandom_range(0, 2) == 0) begin
            zqc_valid_i = 1'b1; zqc_cmd_i = CW'($urandom);
         end
         if (!direct_cmd_valid_i && $urandom_range(0, 1) == 0) begin
            direct_cmd_valid_i = 1'b1; direct_cmd_i = CW'($urandom);
         end
         cmd_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
         if (last_win == N_REF) begin
            ref_valid_i = 1'($urandom_range(0, 1)); ref_cmd_i = CW'($urandom);
         end
         if (last_win == N_ZQC) begin
            zqc_valid_i = 1'($urandom_range(0, 1)); zqc_cmd_i = CW'($urandom);
         end
         if (last_win == N_DIR) begin
            direct_cmd_valid_i = 1'($urandom_range(0, 1)); direct_cmd_i = CW'($urandom);
         end
      end
      ref_valid_i = 1'b0; zqc_valid_i = 1'b0; direct_cmd_valid_i = 1'b0;
      cmd_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("final_idle", 32'(cmd_valid_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
